// File: rtl/fp_pkg.sv
// Shared definitions for the single-precision adder front end: type codes,
// field widths and the per-operand classification helpers.
package fp_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    typedef enum logic [2:0] {
        ZERO      = 3'b000,
        INF       = 3'b001,
        SUBNORMAL = 3'b010,
        NORMAL    = 3'b011,
        NAN       = 3'b100
    } fp_type_e;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
        fp_type_e         typ;
        logic             hidden;
        logic [EXP_W-1:0] eff_exp;
    } fp_unpacked_t;

    function automatic fp_type_e classify_operand(input logic [EXP_W-1:0] exp_f,
                                                  input logic [MAN_W-1:0] man_f);
        fp_type_e t;
        if (exp_f == {EXP_W{1'b0}}) begin
            if (man_f == {MAN_W{1'b0}}) t = ZERO;
            else                        t = SUBNORMAL;
        end else if (exp_f == EXP_MAX) begin
            if (man_f == {MAN_W{1'b0}}) t = INF;
            else                        t = NAN;
        end else begin
            t = NORMAL;
        end
        return t;
    endfunction

    // Subnormals and zero share the exponent of the smallest normal.
    function automatic logic [EXP_W-1:0] effective_exp(input logic [EXP_W-1:0] exp_f);
        logic [EXP_W-1:0] e;
        if (exp_f == {EXP_W{1'b0}}) e = 8'd1;
        else                        e = exp_f;
        return e;
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational unpack of one raw single-precision operand into its fields,
// class, hidden bit and effective exponent.
module fp_classify
    import fp_pkg::*;
(
    input  logic [31:0]   operand,
    output fp_unpacked_t  unpacked
);

    fp_type_e typ_s;

    assign typ_s = classify_operand(operand[30:23], operand[22:0]);

    assign unpacked.sign    = operand[31];
    assign unpacked.exp     = operand[30:23];
    assign unpacked.man     = operand[22:0];
    assign unpacked.typ     = typ_s;
    assign unpacked.hidden  = (typ_s == NORMAL);
    assign unpacked.eff_exp = effective_exp(operand[30:23]);

endmodule

// File: rtl/fp_operand_unpack.sv
// Two-stage operand front end: stage 1 holds the unpacked operands, stage 2
// holds the magnitude ordering and the pass-through fields presented downstream.
module fp_operand_unpack #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_a,
    input  logic [EXP_W+MAN_W:0]   in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   sign_A,
    output logic                   sign_B,
    output logic [EXP_W-1:0]       exp_A,
    output logic [EXP_W-1:0]       exp_B,
    output logic [MAN_W-1:0]       mantis_A,
    output logic [MAN_W-1:0]       mantis_B,
    output logic [2:0]             type_A,
    output logic [2:0]             type_B,
    output logic                   swapped,
    output logic [EXP_W-1:0]       exp_diff,
    output logic [MAN_W:0]         sig_big,
    output logic [MAN_W:0]         sig_small
);

    import fp_pkg::*;

    fp_unpacked_t cls_a_s, cls_b_s;
    fp_unpacked_t s1_a_r, s1_b_r;
    logic         v1_r, v2_r;
    logic         ready1_s, ready2_s;
    logic         swapped_s;
    logic [7:0]   exp_diff_s;
    logic [23:0]  sig_a_s, sig_b_s, sig_big_s, sig_small_s;

    fp_classify u_cls_a (.operand(in_a), .unpacked(cls_a_s));
    fp_classify u_cls_b (.operand(in_b), .unpacked(cls_b_s));

    // A stage may load when it is empty or its content leaves on the same edge.
    assign ready2_s  = ~v2_r | out_ready;
    assign ready1_s  = ~v1_r | ready2_s;
    assign in_ready  = ready1_s & ~rst;
    assign out_valid = v2_r;

    // Stage 1: capture the unpacked operands of an accepted pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r   <= 1'b0;
            s1_a_r <= '0;
            s1_b_r <= '0;
        end else if (ready1_s) begin
            v1_r <= in_valid;
            if (in_valid) begin
                s1_a_r <= cls_a_s;
                s1_b_r <= cls_b_s;
            end
        end
    end

    // Magnitude ordering on the sign-less encoding; ties keep A as the larger.
    always_comb begin
        sig_a_s     = {s1_a_r.hidden, s1_a_r.man};
        sig_b_s     = {s1_b_r.hidden, s1_b_r.man};
        swapped_s   = ({s1_b_r.exp, s1_b_r.man} > {s1_a_r.exp, s1_a_r.man});
        sig_big_s   = sig_a_s;
        sig_small_s = sig_b_s;
        exp_diff_s  = 8'd0;
        if (swapped_s) begin
            sig_big_s   = sig_b_s;
            sig_small_s = sig_a_s;
            exp_diff_s  = s1_b_r.eff_exp - s1_a_r.eff_exp;
        end else begin
            sig_big_s   = sig_a_s;
            sig_small_s = sig_b_s;
            exp_diff_s  = s1_a_r.eff_exp - s1_b_r.eff_exp;
        end
    end

    // Stage 2: registered output bundle, held while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_r      <= 1'b0;
            sign_A    <= 1'b0;
            sign_B    <= 1'b0;
            exp_A     <= 8'd0;
            exp_B     <= 8'd0;
            mantis_A  <= 23'd0;
            mantis_B  <= 23'd0;
            type_A    <= ZERO;
            type_B    <= ZERO;
            swapped   <= 1'b0;
            exp_diff  <= 8'd0;
            sig_big   <= 24'd0;
            sig_small <= 24'd0;
        end else if (ready2_s) begin
            v2_r <= v1_r;
            if (v1_r) begin
                sign_A    <= s1_a_r.sign;
                sign_B    <= s1_b_r.sign;
                exp_A     <= s1_a_r.exp;
                exp_B     <= s1_b_r.exp;
                mantis_A  <= s1_a_r.man;
                mantis_B  <= s1_b_r.man;
                type_A    <= s1_a_r.typ;
                type_B    <= s1_b_r.typ;
                swapped   <= swapped_s;
                exp_diff  <= exp_diff_s;
                sig_big   <= sig_big_s;
                sig_small <= sig_small_s;
            end
        end
    end

endmodule
